// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP CPU port controller.
// The VRAM job record is what the port logic hands to the VRAM request FSM.
package vdp_pkg;

    localparam int VDP_VRAM_AW = 14;

    localparam logic [1:0] PORT_SEL  = 2'b10;
    localparam logic       DATA_PORT = 1'b0;
    localparam logic       CTRL_PORT = 1'b1;

    typedef enum logic [1:0] {
        VRAM_RD = 2'd0,
        VRAM_WR = 2'd1,
        REG_WR  = 2'd2,
        CRAM_WR = 2'd3
    } code_t;

    typedef struct packed {
        logic                   we;
        logic [VDP_VRAM_AW-1:0] addr;
        logic [7:0]             wdata;
    } vram_job_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } vram_state_t;

endpackage

// File: rtl/bus_strobe_sync.sv
// Synchronises the Z80 strobes into clk and flags the start and end of an I/O cycle.
// An I/O cycle is active while IORQ_L is low and at least one of RD_L/WR_L is low.
module bus_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_L,
    input  logic IORQ_L,
    input  logic RD_L,
    input  logic WR_L,
    output logic acc_start,
    output logic acc_end,
    output logic acc_is_rd
);

    logic [SYNC_STAGES-1:0] iorq_q;
    logic [SYNC_STAGES-1:0] rd_q;
    logic [SYNC_STAGES-1:0] wr_q;
    logic                   active;
    logic                   active_q;

    // Strobes idle high, so the chains reset to all ones.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            iorq_q   <= '1;
            rd_q     <= '1;
            wr_q     <= '1;
            active_q <= 1'b0;
        end else begin
            iorq_q   <= {iorq_q[SYNC_STAGES-2:0], IORQ_L};
            rd_q     <= {rd_q[SYNC_STAGES-2:0], RD_L};
            wr_q     <= {wr_q[SYNC_STAGES-2:0], WR_L};
            active_q <= active;
        end
    end

    assign active    = ~iorq_q[SYNC_STAGES-1] & ~(rd_q[SYNC_STAGES-1] & wr_q[SYNC_STAGES-1]);
    assign acc_start = active & ~active_q;
    assign acc_end   = ~active & active_q;
    assign acc_is_rd = ~rd_q[SYNC_STAGES-1];

endmodule

// File: rtl/vdp_cpu_port_ctrl.sv
// Z80-side data/control port controller: command latch, auto-incrementing address,
// read-ahead buffer, VRAM request sequencing, CRAM and register write pulses.
module vdp_cpu_port_ctrl
    import vdp_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int VRAM_AW     = VDP_VRAM_AW,
    parameter int CRAM_AW     = 5
) (
    input  logic               clk,
    input  logic               rst_L,
    input  logic               IORQ_L,
    input  logic               RD_L,
    input  logic               WR_L,
    input  logic [7:0]         addr_bus,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    output logic               data_oe,
    output logic               vram_req,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    input  logic               vram_ack,
    input  logic [7:0]         vram_rdata,
    output logic               cram_we,
    output logic [CRAM_AW-1:0] cram_addr,
    output logic [7:0]         cram_wdata,
    output logic               reg_we,
    output logic [3:0]         reg_idx,
    output logic [7:0]         reg_data,
    input  logic [7:0]         status_in,
    output logic               status_rd,
    output logic               overrun,
    output vram_state_t        dbg_vram_state
);

    logic acc_start, acc_end, acc_is_rd;

    bus_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_L     (rst_L),
        .IORQ_L    (IORQ_L),
        .RD_L      (RD_L),
        .WR_L      (WR_L),
        .acc_start (acc_start),
        .acc_end   (acc_end),
        .acc_is_rd (acc_is_rd)
    );

    logic decode_raw;
    logic unused_addr_bits;
    assign decode_raw       = (addr_bus[7:6] == PORT_SEL);
    assign unused_addr_bits = ^addr_bus[5:1];

    logic [7:0] rd_buf;
    assign data_oe  = ~IORQ_L & ~RD_L & decode_raw;
    assign data_out = data_oe ? ((addr_bus[0] == CTRL_PORT) ? status_in : rd_buf) : 8'h00;

    // Bus cycle details captured when the synced strobe falls.
    logic       cap_decode, cap_port, cap_rd;
    logic [7:0] cap_data;

    logic               flag;
    code_t              code;
    logic [7:0]         low_byte;
    logic [VRAM_AW-1:0] addr, addr_n;

    logic acc, ctrl_wr, ctrl_rd, data_wr, data_rd;
    assign acc     = acc_end & cap_decode & decode_raw;
    assign ctrl_wr = acc & (cap_port == CTRL_PORT) & ~cap_rd;
    assign ctrl_rd = acc & (cap_port == CTRL_PORT) &  cap_rd;
    assign data_wr = acc & (cap_port == DATA_PORT) & ~cap_rd;
    assign data_rd = acc & (cap_port == DATA_PORT) &  cap_rd;

    vram_state_t state, state_n;
    vram_job_t   cur, cur_n, pend, pend_n, job;
    logic        job_v, pend_v, pend_v_n, req_n, ovr_n, rd_done;

    assign rd_done = (state == ST_REQ) & vram_ack & ~cur.we;

    always_comb begin
        job_v = 1'b0;
        job   = '0;
        if (ctrl_wr && flag && code_t'(cap_data[7:6]) == VRAM_RD) begin
            job_v    = 1'b1;
            job.addr = {cap_data[VRAM_AW-9:0], addr[7:0]};
        end
        if (data_wr && code != CRAM_WR) begin
            job_v     = 1'b1;
            job.we    = 1'b1;
            job.addr  = addr;
            job.wdata = cap_data;
        end
        if (data_rd) begin
            job_v    = 1'b1;
            job.addr = addr;
        end
    end

    // Write jobs advance the address when queued; read-ahead advances it on completion.
    always_comb begin
        addr_n = addr;
        if (rd_done) addr_n = addr_n + VRAM_AW'(1);
        if (data_wr) addr_n = addr_n + VRAM_AW'(1);
        if (ctrl_wr && !flag) addr_n[7:0] = cap_data;
        if (ctrl_wr && flag)  addr_n[VRAM_AW-1:8] = cap_data[VRAM_AW-9:0];
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            cap_decode <= 1'b0;
            cap_port   <= 1'b0;
            cap_rd     <= 1'b0;
            cap_data   <= 8'h00;
            flag       <= 1'b0;
            code       <= VRAM_RD;
            low_byte   <= 8'h00;
            addr       <= '0;
            rd_buf     <= 8'h00;
            cram_we    <= 1'b0;
            cram_addr  <= '0;
            cram_wdata <= 8'h00;
            reg_we     <= 1'b0;
            reg_idx    <= 4'h0;
            reg_data   <= 8'h00;
            status_rd  <= 1'b0;
        end else begin
            cram_we   <= 1'b0;
            reg_we    <= 1'b0;
            status_rd <= 1'b0;
            addr      <= addr_n;
            if (acc_start) begin
                cap_decode <= decode_raw;
                cap_port   <= addr_bus[0];
                cap_rd     <= acc_is_rd;
                cap_data   <= data_in;
            end
            if (ctrl_wr) begin
                if (!flag) begin
                    low_byte <= cap_data;
                    flag     <= 1'b1;
                end else begin
                    code <= code_t'(cap_data[7:6]);
                    flag <= 1'b0;
                    if (code_t'(cap_data[7:6]) == REG_WR) begin
                        reg_we   <= 1'b1;
                        reg_idx  <= cap_data[3:0];
                        reg_data <= low_byte;
                    end
                end
            end
            if (ctrl_rd) begin
                status_rd <= 1'b1;
                flag      <= 1'b0;
            end
            if (data_wr) begin
                flag   <= 1'b0;
                rd_buf <= cap_data;
                if (code == CRAM_WR) begin
                    cram_we    <= 1'b1;
                    cram_addr  <= addr[CRAM_AW-1:0];
                    cram_wdata <= cap_data;
                end
            end
            if (data_rd) flag <= 1'b0;
            if (rd_done) rd_buf <= vram_rdata;
        end
    end

    // vram_req/vram_ack handshake: once req rises, req, we, addr and wdata stay
    // stable until the cycle ack is sampled high; that cycle completes the access
    // and carries vram_rdata for reads. A held req after ack is a new request.
    always_comb begin
        state_n  = state;
        req_n    = vram_req;
        cur_n    = cur;
        pend_v_n = pend_v;
        pend_n   = pend;
        ovr_n    = overrun;
        unique case (state)
            ST_IDLE: begin
                if (pend_v) begin
                    cur_n    = pend;
                    req_n    = 1'b1;
                    state_n  = ST_REQ;
                    pend_v_n = job_v;
                    if (job_v) pend_n = job;
                end else if (job_v) begin
                    cur_n   = job;
                    req_n   = 1'b1;
                    state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                if (vram_ack) begin
                    if (pend_v) begin
                        cur_n    = pend;
                        pend_v_n = job_v;
                        if (job_v) pend_n = job;
                    end else begin
                        req_n   = 1'b0;
                        state_n = ST_IDLE;
                        if (job_v) begin
                            pend_v_n = 1'b1;
                            pend_n   = job;
                        end
                    end
                end else if (job_v) begin
                    if (pend_v) begin
                        ovr_n = 1'b1;
                    end else begin
                        pend_v_n = 1'b1;
                        pend_n   = job;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state    <= ST_IDLE;
            vram_req <= 1'b0;
            cur      <= '0;
            pend_v   <= 1'b0;
            pend     <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_n;
            vram_req <= req_n;
            cur      <= cur_n;
            pend_v   <= pend_v_n;
            pend     <= pend_n;
            overrun  <= ovr_n;
        end
    end

    assign vram_we        = cur.we;
    assign vram_addr      = cur.addr;
    assign vram_wdata     = cur.wdata;
    assign dbg_vram_state = state;

endmodule

// File: tb/tb_vdp_cpu_port_ctrl.sv
// Bench for vdp_cpu_port_ctrl: Z80 bus driver tasks, a VRAM arbiter model and
// monitors that check VRAM, CRAM and register traffic against expected queues.
module tb_vdp_cpu_port_ctrl;
    import vdp_pkg::*;

    localparam logic [7:0] DP = 8'hBE;
    localparam logic [7:0] CP = 8'hBF;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic        IORQ_L = 1'b1, RD_L = 1'b1, WR_L = 1'b1;
    logic [7:0]  addr_bus = 8'h00, data_in = 8'h00;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        vram_req, vram_we;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_ack = 1'b0;
    logic [7:0]  vram_rdata = 8'h00;
    logic        cram_we;
    logic [4:0]  cram_addr;
    logic [7:0]  cram_wdata;
    logic        reg_we;
    logic [3:0]  reg_idx;
    logic [7:0]  reg_data;
    logic [7:0]  status_in = 8'hA5;
    logic        status_rd;
    logic        overrun;
    vram_state_t dbg_vram_state;

    vdp_cpu_port_ctrl dut (
        .clk(clk), .rst_L(rst_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
        .addr_bus(addr_bus), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata),
        .cram_we(cram_we), .cram_addr(cram_addr), .cram_wdata(cram_wdata),
        .reg_we(reg_we), .reg_idx(reg_idx), .reg_data(reg_data),
        .status_in(status_in), .status_rd(status_rd), .overrun(overrun),
        .dbg_vram_state(dbg_vram_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [22:0] exp_vram_q[$];
    logic [12:0] exp_cram_q[$];
    logic [11:0] exp_reg_q[$];

    logic        ack_en = 1'b1;
    logic [7:0]  rdata_val = 8'h00;
    int          ack_wait = 0;
    int          status_cnt = 0;
    logic [22:0] e_v, o_v;
    logic [12:0] e_c;
    logic [11:0] e_r;

    // VRAM arbiter model: grants after a random delay and checks each completed access.
    always @(negedge clk) begin
        if (vram_ack) begin
            vram_ack = 1'b0;
        end else if (vram_req && ack_en) begin
            if (ack_wait == 0) begin
                o_v = {vram_we, vram_addr, vram_we ? vram_wdata : 8'h00};
                total++;
                if (exp_vram_q.size() == 0) begin
                    bad++;
                    $display("FAIL vram_unexpected: got we=%b addr=%h wdata=%h, required no access",
                             vram_we, vram_addr, vram_wdata);
                end else begin
                    e_v = exp_vram_q.pop_front();
                    if (o_v !== e_v) begin
                        bad++;
                        $display("FAIL vram_access: got %h, required %h", o_v, e_v);
                    end
                end
                vram_rdata = rdata_val;
                vram_ack   = 1'b1;
                ack_wait   = $urandom_range(0, 3);
            end else begin
                ack_wait--;
            end
        end
    end

    always @(negedge clk) begin
        if (status_rd) status_cnt++;
        if (cram_we) begin
            total++;
            if (exp_cram_q.size() == 0) begin
                bad++;
                $display("FAIL cram_unexpected: got addr=%h data=%h, required none", cram_addr, cram_wdata);
            end else begin
                e_c = exp_cram_q.pop_front();
                if ({cram_addr, cram_wdata} !== e_c) begin
                    bad++;
                    $display("FAIL cram_write: got %h, required %h", {cram_addr, cram_wdata}, e_c);
                end
            end
        end
        if (reg_we) begin
            total++;
            if (exp_reg_q.size() == 0) begin
                bad++;
                $display("FAIL reg_unexpected: got idx=%h data=%h, required none", reg_idx, reg_data);
            end else begin
                e_r = exp_reg_q.pop_front();
                if ({reg_idx, reg_data} !== e_r) begin
                    bad++;
                    $display("FAIL reg_write: got %h, required %h", {reg_idx, reg_data}, e_r);
                end
            end
        end
    end

    task automatic io_write(input logic [7:0] port, input logic [7:0] d);
        @(posedge clk); #1;
        addr_bus = port;
        data_in  = d;
        IORQ_L   = 1'b0;
        WR_L     = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        IORQ_L = 1'b1;
        WR_L   = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic io_read(input logic [7:0] port, output logic [7:0] d, output logic oe);
        @(posedge clk); #1;
        addr_bus = port;
        IORQ_L   = 1'b0;
        RD_L     = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        d  = data_out;
        oe = data_oe;
        @(posedge clk); #1;
        IORQ_L = 1'b1;
        RD_L   = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_vram_q.size() != 0 || exp_cram_q.size() != 0 || exp_reg_q.size() != 0 || vram_req)
               && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        total++;
        if (n >= 400) begin
            bad++;
            $display("FAIL %s_drain: left vram=%0d cram=%0d reg=%0d req=%b, required all zero",
                     name, exp_vram_q.size(), exp_cram_q.size(), exp_reg_q.size(), vram_req);
        end
    endtask

    task automatic test_reset();
        rst_L = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total += 8;
        if (vram_req !== 1'b0)   begin bad++; $display("FAIL rst_vram_req: got %b, required 0", vram_req); end
        if (vram_we !== 1'b0)    begin bad++; $display("FAIL rst_vram_we: got %b, required 0", vram_we); end
        if (vram_addr !== 14'h0) begin bad++; $display("FAIL rst_vram_addr: got %h, required 0", vram_addr); end
        if (cram_we !== 1'b0)    begin bad++; $display("FAIL rst_cram_we: got %b, required 0", cram_we); end
        if (reg_we !== 1'b0)     begin bad++; $display("FAIL rst_reg_we: got %b, required 0", reg_we); end
        if (status_rd !== 1'b0)  begin bad++; $display("FAIL rst_status_rd: got %b, required 0", status_rd); end
        if (overrun !== 1'b0)    begin bad++; $display("FAIL rst_overrun: got %b, required 0", overrun); end
        if (data_out !== 8'h00 || data_oe !== 1'b0) begin
            bad++; $display("FAIL rst_data: got out=%h oe=%b, required 00/0", data_out, data_oe);
        end
        rst_L = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_vram_write();
        logic [7:0] d;
        logic oe;
        exp_vram_q.push_back({1'b1, 14'h0000, 8'hAA});
        exp_vram_q.push_back({1'b1, 14'h0001, 8'hBB});
        io_write(CP, 8'h00);
        io_write(CP, 8'h40);
        io_write(DP, 8'hAA);
        io_write(DP, 8'hBB);
        wait_drain("vram_write");
        // Address must now be 0x0002; a data read returns the last written byte.
        rdata_val = 8'h3C;
        exp_vram_q.push_back({1'b0, 14'h0002, 8'h00});
        io_read(DP, d, oe);
        total += 2;
        if (d !== 8'hBB) begin bad++; $display("FAIL vw_rdbuf: got %h, required bb", d); end
        if (oe !== 1'b1) begin bad++; $display("FAIL vw_oe: got %b, required 1", oe); end
        wait_drain("vram_write_rd");
    endtask

    task automatic test_prefetch();
        logic [7:0] d;
        logic oe;
        rdata_val = 8'h5E;
        exp_vram_q.push_back({1'b0, 14'h1234, 8'h00});
        io_write(CP, 8'h34);
        io_write(CP, 8'h12);
        wait_drain("prefetch");
        rdata_val = 8'h77;
        exp_vram_q.push_back({1'b0, 14'h1235, 8'h00});
        io_read(DP, d, oe);
        total++;
        if (d !== 8'h5E) begin bad++; $display("FAIL pf_read1: got %h, required 5e", d); end
        wait_drain("prefetch_rd1");
        rdata_val = 8'h00;
        exp_vram_q.push_back({1'b0, 14'h1236, 8'h00});
        io_read(DP, d, oe);
        total++;
        if (d !== 8'h77) begin bad++; $display("FAIL pf_read2: got %h, required 77", d); end
        wait_drain("prefetch_rd2");
    endtask

    task automatic test_reg_write();
        exp_reg_q.push_back({4'h1, 8'h07});
        io_write(CP, 8'h07);
        io_write(CP, 8'h81);
        wait_drain("reg_write");
    endtask

    task automatic test_cram_write();
        exp_cram_q.push_back({5'd3, 8'h3F});
        io_write(CP, 8'h03);
        io_write(CP, 8'hC0);
        io_write(DP, 8'h3F);
        wait_drain("cram_write");
    endtask

    task automatic test_wrap();
        logic [7:0] a, b;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        exp_vram_q.push_back({1'b1, 14'h3FFF, a});
        exp_vram_q.push_back({1'b1, 14'h0000, b});
        io_write(CP, 8'hFF);
        io_write(CP, 8'h7F);
        io_write(DP, a);
        io_write(DP, b);
        wait_drain("wrap");
    endtask

    task automatic test_status();
        logic [7:0] d;
        logic oe;
        int cnt0;
        cnt0 = status_cnt;
        status_in = 8'h5A;
        io_write(CP, 8'h11);
        io_read(CP, d, oe);
        total += 3;
        if (d !== 8'h5A) begin bad++; $display("FAIL st_data: got %h, required 5a", d); end
        if (oe !== 1'b1) begin bad++; $display("FAIL st_oe: got %b, required 1", oe); end
        if (status_cnt - cnt0 !== 1) begin
            bad++; $display("FAIL st_pulse: got %0d pulses, required 1", status_cnt - cnt0);
        end
        exp_vram_q.push_back({1'b1, 14'h0000, 8'h66});
        io_write(CP, 8'h00);
        io_write(CP, 8'h40);
        io_write(DP, 8'h66);
        wait_drain("status");
    endtask

    task automatic test_no_decode();
        logic [7:0] d;
        logic oe;
        io_write(8'h7F, 8'h55);
        io_read(8'h7E, d, oe);
        total++;
        if (oe !== 1'b0 || d !== 8'h00) begin
            bad++; $display("FAIL nodec_read: got oe=%b data=%h, required 0/00", oe, d);
        end
        wait_drain("no_decode");
    endtask

    task automatic test_back_to_back();
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_pre: got %b, required 0", overrun); end
        ack_en = 1'b0;
        io_write(CP, 8'h00);
        io_write(CP, 8'h41);
        io_write(DP, 8'h01);
        io_write(DP, 8'h02);
        io_write(DP, 8'h03);
        total += 3;
        if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b, required 1", overrun); end
        if (vram_req !== 1'b1) begin bad++; $display("FAIL ovr_req: got %b, required 1", vram_req); end
        if ({vram_we, vram_addr, vram_wdata} !== {1'b1, 14'h0100, 8'h01}) begin
            bad++; $display("FAIL ovr_held: got %h, required %h",
                            {vram_we, vram_addr, vram_wdata}, {1'b1, 14'h0100, 8'h01});
        end
        exp_vram_q.push_back({1'b1, 14'h0100, 8'h01});
        exp_vram_q.push_back({1'b1, 14'h0101, 8'h02});
        ack_en = 1'b1;
        wait_drain("back_to_back");
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b, required 1", overrun); end
    endtask

    task automatic test_reset_mid_req();
        ack_en = 1'b0;
        io_write(CP, 8'h00);
        io_write(CP, 8'h40);
        io_write(DP, 8'h99);
        io_write(DP, 8'h98);
        total++;
        if (vram_req !== 1'b1) begin bad++; $display("FAIL mid_req_pre: got %b, required 1", vram_req); end
        @(posedge clk); #3;
        rst_L = 1'b0;
        #1;
        total += 2;
        if (vram_req !== 1'b0) begin bad++; $display("FAIL mid_req_async: got %b, required 0", vram_req); end
        if (overrun !== 1'b0)  begin bad++; $display("FAIL mid_ovr_clr: got %b, required 0", overrun); end
        repeat (2) @(posedge clk);
        #1;
        rst_L  = 1'b1;
        ack_en = 1'b1;
        repeat (40) @(negedge clk);
        total++;
        if (vram_req !== 1'b0) begin bad++; $display("FAIL mid_pend_gone: got %b, required 0", vram_req); end
    endtask

    initial begin
        test_reset();
        test_vram_write();
        test_prefetch();
        test_reg_write();
        test_cram_write();
        test_wrap();
        test_status();
        test_no_decode();
        test_back_to_back();
        test_reset_mid_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
